// File: rtl/dht11_responder.sv
// dht11_responder: DHT11 sensor emulator answering a host start pulse with the ack and a 40-bit frame.
module dht11_responder #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int START_MIN_US  = 18000,
  parameter int RESP_DELAY_US = 30
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  inout  wire         dht11,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        frame_done
);
  localparam int DIV     = CLK_FREQ / 1_000_000;
  localparam int START_C = START_MIN_US * DIV;
  localparam int RESP_C  = RESP_DELAY_US * DIV;
  localparam int ACK_C   = 80 * DIV;
  localparam int LOW_C   = 50 * DIV;
  localparam int ONE_C   = 70 * DIV;
  localparam int ZERO_C  = 26 * DIV;
  localparam int MAXC    = START_C > RESP_C ? (START_C > ACK_C ? START_C : ACK_C)
                                            : (RESP_C > ACK_C ? RESP_C : ACK_C);
  localparam int CW      = $clog2(MAXC + 1);
  typedef enum logic [2:0] {IDLE, START_LOW, WAIT_REL, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW} state_t;
  state_t        state_q, state_d;
  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d, lim;
  logic [39:0]   sr_q, sr_d;
  logic [5:0]    idx_q, idx_d;
  logic          fd_q, fd_d;
  logic          tdone, acc;
  logic [7:0]    sum;
  assign sum = data_in[31:24] + data_in[23:16] + data_in[15:8] + data_in[7:0];
  assign acc = cnt_q == CW'(START_C - 1);
  assign busy = !(state_q == IDLE || state_q == START_LOW);
  assign frame_done = fd_q;
  assign dht11 = (state_q == ACK_LOW || state_q == BIT_LOW || state_q == END_LOW) ? 1'b0 : 1'bz;
  always_comb begin
    lim = state_q == WAIT_REL ? CW'(RESP_C) :
          (state_q == ACK_LOW || state_q == ACK_HIGH) ? CW'(ACK_C) :
          state_q == BIT_HIGH ? (sr_q[39] ? CW'(ONE_C) : CW'(ZERO_C)) : CW'(LOW_C);
    tdone = cnt_q == lim - 1'b1;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = tdone ? '0 : cnt_q + 1'b1;
    sr_d    = sr_q;
    idx_d   = idx_q;
    fd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!s2_q) state_d = START_LOW;
      end
      START_LOW: begin
        // the IDLE sample is the first low cycle, so a full start ends at START_C-1
        cnt_d = acc ? cnt_q : cnt_q + 1'b1;
        if (s2_q) begin
          cnt_d   = '0;
          state_d = acc ? WAIT_REL : IDLE;
          if (acc) begin
            sr_d  = {data_in, sum};
            idx_d = '0;
          end
        end
      end
      WAIT_REL: if (tdone) state_d = ACK_LOW;
      ACK_LOW:  if (tdone) state_d = ACK_HIGH;
      ACK_HIGH: if (tdone) state_d = BIT_LOW;
      BIT_LOW:  if (tdone) state_d = BIT_HIGH;
      BIT_HIGH: if (tdone) begin
        sr_d    = {sr_q[38:0], 1'b0};
        state_d = idx_q == 6'd39 ? END_LOW : BIT_LOW;
        idx_d   = idx_q == 6'd39 ? idx_q : idx_q + 1'b1;
      end
      END_LOW: if (tdone) begin
        state_d = IDLE;
        fd_d    = 1'b1;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      cnt_q   <= '0;
      sr_q    <= '0;
      idx_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= dht11;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      fd_q    <= fd_d;
    end
  end
endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: host BFM plus run-length bus monitor checked against a frame/timing model.
module tb_dht11_responder;
  logic        clk = 0, rst = 1, host_low = 0;
  logic [31:0] din = 0;
  wire         dht11;
  logic        busy, frame_done;
  int          total = 0, bad = 0, fd_cnt = 0;
  logic        pb = 1, pbusy = 0;
  bit          cur_s;
  pullup (dht11);
  assign dht11 = host_low ? 1'b0 : 1'bz;
  always #5 clk = ~clk;
  dht11_responder #(.CLK_FREQ(2_000_000), .START_MIN_US(100)) dut (
    .sys_clk(clk), .sys_rst(rst), .dht11(dht11), .data_in(din), .busy(busy), .frame_done(frame_done));
  typedef struct {logic [31:0] d; int low; bit chg; bit acc; bit has_chk; logic [7:0] chk;} vec_t;
  vec_t vt[6];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  function automatic logic [39:0] model(input logic [31:0] d);
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'(d[8*i +: 8]);
    return {d, 8'(s % 256)};
  endfunction
  always @(negedge clk) begin
    if (frame_done) begin
      fd_cnt++;
      total++;
      if (!(pb == 1'b0 && dht11 === 1'b1 && pbusy && !busy)) begin
        bad++;
        $display("FAIL fd_align: got bus %b->%b busy %b->%b want 0->1 1->0", pb, dht11, pbusy, busy);
      end
    end
    pb = dht11;
    pbusy = busy;
  end
  task automatic get_run(output bit lvl, output int len);
    lvl = cur_s;
    len = 1;
    forever begin
      @(negedge clk);
      if (dht11 !== lvl || len >= 400) begin
        cur_s = dht11;
        break;
      end
      len++;
    end
  endtask
  task automatic host_start(input int low);
    @(posedge clk); #1 host_low = 1;
    repeat (low) @(posedge clk);
    #1 host_low = 0;
  endtask
  task automatic do_frame(input vec_t v, input int rst_bit);
    logic [39:0] exp_f, got;
    int explen[$];
    bit l;
    int n, fd0;
    exp_f = model(v.d);
    got = '0;
    din = v.d;
    host_start(v.low);
    fd0 = fd_cnt;
    @(negedge clk);
    cur_s = dht11;
    if (!v.acc) begin
      n = 0;
      repeat (300) begin
        if (dht11 !== 1'b1 || busy) n++;
        @(negedge clk);
      end
      chk("reject_quiet", n, 0);
      chk("reject_fd", fd_cnt - fd0, 0);
      return;
    end
    explen = {63, 160, 160};
    for (int i = 0; i < 40; i++) begin
      explen.push_back(100);
      explen.push_back(exp_f[39-i] ? 140 : 52);
    end
    explen.push_back(100);
    for (int i = 0; i < explen.size(); i++) begin
      if (rst_bit >= 0 && i == 3 + 2 * rst_bit) begin
        repeat (20) @(negedge clk);
        #3 rst = 1;
        #1 chk("rst_bus", dht11, 1);
        chk("rst_busy", busy, 0);
        chk("rst_fd", frame_done, 0);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        repeat (100) @(negedge clk);
        chk("rst_no_fd", fd_cnt - fd0, 0);
        return;
      end
      get_run(l, n);
      chk($sformatf("run%0d", i), {l, n}, {i % 2 == 0, explen[i]});
      if (i >= 3 && i % 2 == 0) got = {got[38:0], n > 96};
      if (i == 0) begin
        chk("busy_ack", busy, 1);
        if (v.chg) din = 32'h0;
      end
    end
    repeat (3) @(negedge clk);
    chk("frame_bits", got, exp_f);
    if (v.has_chk) chk("checksum", got[7:0], v.chk);
    chk("fd_once", fd_cnt - fd0, 1);
    chk("idle_busy", busy, 0);
  endtask
  initial begin
    int fd0;
    vec_t r;
    vt[0] = '{32'h3700_1A05, 240, 1'b0, 1'b1, 1'b1, 8'h56};
    vt[1] = '{32'hFFFF_FFFF, 200, 1'b0, 1'b1, 1'b1, 8'hFC};
    vt[2] = '{$urandom, 120, 1'b0, 1'b0, 1'b0, 8'h0};
    vt[3] = '{$urandom, 199, 1'b0, 1'b0, 1'b0, 8'h0};
    vt[4] = '{$urandom, 240, 1'b1, 1'b1, 1'b0, 8'h0};
    vt[5] = '{$urandom, 201, 1'b0, 1'b1, 1'b0, 8'h0};
    repeat (3) @(negedge clk);
    chk("reset_bus", dht11, 1);
    chk("reset_busy", busy, 0);
    chk("reset_fd", frame_done, 0);
    @(posedge clk); #1 rst = 0;
    repeat (5) @(negedge clk);
    chk("idle_bus", dht11, 1);
    chk("idle_busy0", busy, 0);
    for (int k = 0; k < 6; k++) do_frame(vt[k], -1);
    r = '{$urandom, 240, 1'b0, 1'b1, 1'b0, 8'h0};
    do_frame(r, 10);
    fd0 = fd_cnt;
    r.d = $urandom;
    do_frame(r, -1);
    repeat (2000) @(negedge clk);
    r.d = $urandom;
    do_frame(r, -1);
    chk("b2b_fd", fd_cnt - fd0, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
